// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, arbiter state encoding and
// the sel decode used by the output-port switch arbiter.
package noc_pkg;

    localparam int PORTW = 5;
    localparam int DATAW = 33;
    localparam int VCHW  = 2;

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } arb_state_e;

    function automatic logic [1:0] sel_onehot(input arb_state_e st);
        case (st)
            LOCK0:   sel_onehot = 2'b01;
            LOCK1:   sel_onehot = 2'b10;
            default: sel_onehot = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin winner: the input that did not win last time
// has priority; the other wins only when it requests alone.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       any,
    output logic       win
);

    // Priority pick between the two head requests.
    always_comb begin
        any = req[0] | req[1];
        if (req[~last]) begin
            win = ~last;
        end else begin
            win = last;
        end
    end

endmodule

// File: rtl/mux_sw_arbiter.sv
// Packet-locking round-robin arbiter for a 2:1 output-port mux: holds the
// port on one input from HEAD through TAIL and enforces a packet length cap.
module mux_sw_arbiter #(
    parameter int TYPEW  = 2,
    parameter int PORTW  = noc_pkg::PORTW,
    parameter int MAXLEN = 64
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             ivalid_1,
    input  logic             ordy,
    output logic [PORTW-1:0] sel,
    output logic             grant_0,
    output logic             grant_1,
    output logic             busy,
    output logic             err_seq,
    output logic             err_len
);
    import noc_pkg::*;

    localparam int               CNTW     = $clog2(MAXLEN + 1);
    localparam logic [CNTW-1:0]  CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(MAXLEN - 1);
    localparam logic [TYPEW-1:0] T_HEAD   = TYPEW'(TYPE_HEAD);
    localparam logic [TYPEW-1:0] T_DATA   = TYPEW'(TYPE_DATA);
    localparam logic [TYPEW-1:0] T_TAIL   = TYPEW'(TYPE_TAIL);

    arb_state_e       state_r;
    logic             last_r;
    logic [CNTW-1:0]  cnt_r;

    logic [1:0]       hreq_s;
    logic             any_s;
    logic             win_s;
    logic             lock_valid_s;
    logic [TYPEW-1:0] lock_type_s;
    logic             lock_grant_s;
    logic             tail_s;
    logic             len_hit_s;
    logic             stray_s;
    logic [PORTW-1:0] sel_s;

    rr_pick2 u_pick (
        .req  (hreq_s),
        .last (last_r),
        .any  (any_s),
        .win  (win_s)
    );

    // Head requests, locked-input view and the per-cycle transfer decision.
    always_comb begin
        hreq_s[0] = ivalid_0 && (itype_0 == T_HEAD);
        hreq_s[1] = ivalid_1 && (itype_1 == T_HEAD);
        case (state_r)
            LOCK0: begin
                lock_valid_s = ivalid_0;
                lock_type_s  = itype_0;
            end
            LOCK1: begin
                lock_valid_s = ivalid_1;
                lock_type_s  = itype_1;
            end
            default: begin
                lock_valid_s = 1'b0;
                lock_type_s  = {TYPEW{1'b0}};
            end
        endcase
        lock_grant_s = lock_valid_s && ordy;
        tail_s       = (lock_type_s == T_TAIL);
        len_hit_s    = lock_grant_s && !tail_s && (cnt_r == CNT_LAST);
        // DATA/TAIL with no lock held is a sequencing error; it is never granted.
        stray_s      = (state_r == IDLE) &&
                       ((ivalid_0 && ((itype_0 == T_DATA) || (itype_0 == T_TAIL))) ||
                        (ivalid_1 && ((itype_1 == T_DATA) || (itype_1 == T_TAIL))));
    end

    // Mux select decoded straight from the state register.
    always_comb begin
        sel_s      = {PORTW{1'b0}};
        sel_s[1:0] = sel_onehot(state_r);
    end

    // Lock FSM, round-robin pointer and flit counter.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (any_s) begin
                        state_r <= win_s ? LOCK1 : LOCK0;
                        last_r  <= win_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCK0, LOCK1: begin
                    if (lock_grant_s && tail_s) begin
                        // Hand over at the tail edge so back-to-back packets need no bubble.
                        cnt_r <= CNT_ZERO;
                        if (any_s) begin
                            state_r <= win_s ? LOCK1 : LOCK0;
                            last_r  <= win_s;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (len_hit_s) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= IDLE;
                    end else if (lock_grant_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign sel     = sel_s;
    assign grant_0 = lock_grant_s && (state_r == LOCK0);
    assign grant_1 = lock_grant_s && (state_r == LOCK1);
    assign busy    = (state_r != IDLE);
    assign err_seq = rst_ && stray_s;
    assign err_len = len_hit_s;

endmodule

// File: tb/tb_mux_sw_arbiter.sv
// Randomised and directed bench for mux_sw_arbiter; two instances (MAXLEN 64
// and 8) share stimulus and are each compared to a behavioural model.
module tb_mux_sw_arbiter;
    import noc_pkg::*;

    logic       clk;
    logic       rst_;
    logic [1:0] itype_0, itype_1;
    logic       ivalid_0, ivalid_1, ordy;
    logic [4:0] sel_a, sel_b;
    logic       g0_a, g1_a, busy_a, eseq_a, elen_a;
    logic       g0_b, g1_b, busy_b, eseq_b, elen_b;

    mux_sw_arbiter dut_a (
        .clk(clk), .rst_(rst_),
        .itype_0(itype_0), .ivalid_0(ivalid_0),
        .itype_1(itype_1), .ivalid_1(ivalid_1),
        .ordy(ordy), .sel(sel_a), .grant_0(g0_a), .grant_1(g1_a),
        .busy(busy_a), .err_seq(eseq_a), .err_len(elen_a)
    );

    mux_sw_arbiter #(.MAXLEN(8)) dut_b (
        .clk(clk), .rst_(rst_),
        .itype_0(itype_0), .ivalid_0(ivalid_0),
        .itype_1(itype_1), .ivalid_1(ivalid_1),
        .ordy(ordy), .sel(sel_b), .grant_0(g0_b), .grant_1(g1_b),
        .busy(busy_b), .err_seq(eseq_b), .err_len(elen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // input buffers (front = flit presented) and drive controls
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    logic en0, en1, ordy_v, rst_v;

    // behavioural model per instance: owner (-1 none), pointer, flits granted
    int m_own[2], m_last[2], m_cnt[2];
    int m_max[2] = '{64, 8};

    logic [4:0] o_sel[2];
    logic o_g0[2], o_g1[2], o_busy[2], o_eseq[2], o_elen[2];
    logic e_g0[2], e_g1[2];
    int cnt_g0_a, cnt_g1_a, cnt_elen_b, cnt_eseq_b, cnt_idle_a;
    bit track_idle = 1'b0;

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = -1; m_last[d] = 1; m_cnt[d] = 0;
        end
    endtask

    task automatic clear_counts();
        cnt_g0_a = 0; cnt_g1_a = 0; cnt_elen_b = 0; cnt_eseq_b = 0; cnt_idle_a = 0;
    endtask

    function automatic int rr_winner(int last, bit h0, bit h1);
        int pref = 1 - last;
        bit hp = (pref == 0) ? h0 : h1;
        return hp ? pref : last;
    endfunction

    task automatic step();
        bit h0, h1, g0, g1, seq, elen, gk;
        logic [1:0] tk;
        logic [4:0] esel;
        int w;
        @(negedge clk);
        rst_     = rst_v;
        ordy     = ordy_v;
        ivalid_0 = en0 && (q0.size() > 0);
        itype_0  = (q0.size() > 0) ? q0[0] : 2'($urandom_range(0, 3));
        ivalid_1 = en1 && (q1.size() > 0);
        itype_1  = (q1.size() > 0) ? q1[0] : 2'($urandom_range(0, 3));
        #1;
        o_sel[0] = sel_a; o_g0[0] = g0_a; o_g1[0] = g1_a; o_busy[0] = busy_a; o_eseq[0] = eseq_a; o_elen[0] = elen_a;
        o_sel[1] = sel_b; o_g0[1] = g0_b; o_g1[1] = g1_b; o_busy[1] = busy_b; o_eseq[1] = eseq_b; o_elen[1] = elen_b;
        h0 = ivalid_0 && (itype_0 == TYPE_HEAD);
        h1 = ivalid_1 && (itype_1 == TYPE_HEAD);
        for (int d = 0; d < 2; d++) begin
            g0 = 1'b0; g1 = 1'b0; seq = 1'b0; elen = 1'b0; esel = 5'b00000;
            if (rst_ && m_own[d] < 0) begin
                seq = (ivalid_0 && (itype_0 == TYPE_DATA || itype_0 == TYPE_TAIL)) ||
                      (ivalid_1 && (itype_1 == TYPE_DATA || itype_1 == TYPE_TAIL));
            end else if (rst_) begin
                esel = 5'(1 << m_own[d]);
                tk   = (m_own[d] == 0) ? itype_0 : itype_1;
                if (m_own[d] == 0) g0 = ivalid_0 && ordy;
                else               g1 = ivalid_1 && ordy;
                elen = (g0 || g1) && (m_cnt[d] == m_max[d] - 1) && (tk != TYPE_TAIL);
            end
            e_g0[d] = g0; e_g1[d] = g1;
            check($sformatf("sel[%0d]", d),     o_sel[d],  esel);
            check($sformatf("grant_0[%0d]", d), o_g0[d],   g0);
            check($sformatf("grant_1[%0d]", d), o_g1[d],   g1);
            check($sformatf("busy[%0d]", d),    o_busy[d], rst_ && (m_own[d] >= 0));
            check($sformatf("err_seq[%0d]", d), o_eseq[d], seq);
            check($sformatf("err_len[%0d]", d), o_elen[d], elen);
        end
        cnt_g0_a   += int'(o_g0[0]);
        cnt_g1_a   += int'(o_g1[0]);
        cnt_elen_b += int'(o_elen[1]);
        cnt_eseq_b += int'(o_eseq[1]);
        if (track_idle && !o_busy[0]) cnt_idle_a++;
        @(posedge clk);
        // buffers pop on the reference grant; a stray flit with no lock is flushed upstream
        if (e_g0[0]) void'(q0.pop_front());
        else if (rst_ && m_own[0] < 0 && ivalid_0 && itype_0 != TYPE_HEAD) void'(q0.pop_front());
        if (e_g1[0]) void'(q1.pop_front());
        else if (rst_ && m_own[0] < 0 && ivalid_1 && itype_1 != TYPE_HEAD) void'(q1.pop_front());
        for (int d = 0; d < 2; d++) begin
            if (!rst_) begin
                m_own[d] = -1; m_last[d] = 1; m_cnt[d] = 0;
            end else if (m_own[d] < 0) begin
                if (h0 || h1) begin
                    w = rr_winner(m_last[d], h0, h1);
                    m_own[d] = w; m_last[d] = w; m_cnt[d] = 0;
                end
            end else begin
                gk = (m_own[d] == 0) ? e_g0[d] : e_g1[d];
                tk = (m_own[d] == 0) ? itype_0 : itype_1;
                if (gk) begin
                    if (tk == TYPE_TAIL) begin
                        m_cnt[d] = 0;
                        if (h0 || h1) begin
                            w = rr_winner(m_last[d], h0, h1);
                            m_own[d] = w; m_last[d] = w;
                        end else begin
                            m_own[d] = -1;
                        end
                    end else if (m_cnt[d] == m_max[d] - 1) begin
                        m_own[d] = -1; m_cnt[d] = 0;
                    end else begin
                        m_cnt[d]++;
                    end
                end
            end
        end
    endtask

    task automatic push_pkt(input int port, input int len, input bit rnd);
        logic [1:0] f;
        int r;
        for (int i = 0; i < len; i++) begin
            if (i == 0)            f = TYPE_HEAD;
            else if (i == len - 1) f = TYPE_TAIL;
            else if (rnd) begin
                r = int'($urandom_range(0, 9));
                f = (r == 0) ? TYPE_HEAD : (r == 1) ? TYPE_NONE : TYPE_DATA;
            end else f = TYPE_DATA;
            if (port == 0) q0.push_back(f);
            else           q1.push_back(f);
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_own[0] >= 0) && n < budget) begin
            step();
            n++;
        end
        check(tag, (q0.size() == 0 && q1.size() == 0 && m_own[0] < 0), 1);
    endtask

    int g_before;
    int plen;

    initial begin
        rst_ = 1'b0; rst_v = 1'b0; ordy = 1'b1; ordy_v = 1'b1;
        en0 = 1'b1; en1 = 1'b1;
        ivalid_0 = 1'b0; ivalid_1 = 1'b0; itype_0 = TYPE_NONE; itype_1 = TYPE_NONE;
        reset_model();
        clear_counts();
        repeat (3) step();
        rst_v = 1'b1;

        // single 22-flit packet on input 1 after two idle cycles
        repeat (2) step();
        push_pkt(1, 22, 1'b0);
        clear_counts();
        drain("pkt22 drain", 60);
        check("pkt22 grant_1 cycles", cnt_g1_a, 22);
        check("maxlen8 err_len count", cnt_elen_b, 1);
        check("maxlen8 err_seq count", cnt_eseq_b, 14);

        // simultaneous heads: input 0 first, handover without bubble
        push_pkt(0, 4, 1'b0);
        push_pkt(1, 3, 1'b0);
        step();
        step();
        check("tie first lock", o_sel[0], 5'b00001);
        clear_counts();
        track_idle = 1'b1;
        drain("tie drain", 40);
        track_idle = 1'b0;
        check("tie handover bubbles", cnt_idle_a, 0);
        push_pkt(0, 3, 1'b0);
        push_pkt(1, 3, 1'b0);
        step();
        step();
        check("second tie lock", o_sel[0], 5'b00001);
        drain("tie2 drain", 40);

        // 5-cycle ordy stall mid-packet on an exactly-MAXLEN(8) packet
        clear_counts();
        push_pkt(0, 8, 1'b0);
        repeat (4) step();
        ordy_v = 1'b0;
        g_before = cnt_g0_a;
        repeat (5) step();
        check("stall grants", cnt_g0_a - g_before, 0);
        ordy_v = 1'b1;
        drain("stall drain", 40);
        check("stall packet grants", cnt_g0_a, 8);
        check("stall err_len", cnt_elen_b, 0);

        // stray DATA in IDLE
        q0.push_back(TYPE_DATA);
        step();
        check("stray err_seq", o_eseq[0], 1);
        check("stray grant_0", o_g0[0], 0);
        check("stray sel", o_sel[0], 5'b00000);

        // asynchronous reset mid-packet
        push_pkt(1, 12, 1'b0);
        repeat (4) step();
        #3;
        rst_ = 1'b0; rst_v = 1'b0;
        #1;
        check("async sel_a", sel_a, 5'b00000);
        check("async busy_a", busy_a, 0);
        check("async sel_b", sel_b, 5'b00000);
        check("async busy_b", busy_b, 0);
        check("async grant_1", g1_a, 0);
        reset_model();
        q0.delete();
        q1.delete();
        repeat (2) step();
        rst_v = 1'b1;
        push_pkt(0, 3, 1'b0);
        step();
        step();
        check("post-reset lock", o_sel[0], 5'b00001);
        drain("post-reset drain", 20);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            ordy_v = ($urandom_range(0, 3) != 0);
            en0    = ($urandom_range(0, 4) != 0);
            en1    = ($urandom_range(0, 4) != 0);
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) begin
                plen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(2, 12));
                push_pkt(0, plen, 1'b1);
            end
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) begin
                plen = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(2, 12));
                push_pkt(1, plen, 1'b1);
            end
            step();
        end
        en0 = 1'b1; en1 = 1'b1; ordy_v = 1'b1;
        drain("final drain", 400);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
